mem_wb_skid_n: RTL

Parametrised MEM/WB pipeline stage for the superscalar core.
- Carries NUM_LANES writeback bundles as one issue group, with a valid/ready handshake.
- A two-entry skid buffer gives full throughput with a registered in_ready.
- Adds stall, flush, bubble tracking and x0-write suppression.
- Sits between the per-lane MEM stages and the register-file write ports.

---
 rtl/mem_wb_pkg.sv | 34 +++
 rtl/pipe_skid_buf.sv | 89 ++++++++
 rtl/mem_wb_skid_n.sv | 105 ++++++++++
 3 files changed

// File: rtl/mem_wb_pkg.sv
// Shared types and defaults for the MEM/WB writeback stage.
// - result_src_e : writeback result select encoding
// - wb_lane_t    : one lane's writeback bundle at the default widths; the top packs lanes in
//                  this same field order (regwrite MSB ... pc_plus4 LSB)
// - occ_count    : entry count from the two valid bits of a two-entry buffer
package mem_wb_pkg;

  localparam int unsigned NumLanesDef = 2;
  localparam int unsigned XlenDef     = 32;
  localparam int unsigned RegAwDef    = 5;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_RSV = 2'b11
  } result_src_e;

  typedef struct packed {
    logic                regwrite;
    result_src_e         result_src;
    logic [XlenDef-1:0]  alu_result;
    logic [XlenDef-1:0]  read_data;
    logic [RegAwDef-1:0] rd;
    logic [XlenDef-1:0]  pc_plus4;
  } wb_lane_t;

  localparam int unsigned LaneWDef = $bits(wb_lane_t);

  function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
    return {main_v & skid_v, main_v ^ skid_v};
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry skid buffer over a W-bit packed payload.
// The main entry drives the outputs; the skid entry catches a group accepted while the
// consumer stalls, so in_ready can be a flop without losing throughput.
// Ports:
//   clk, rst (async, active-low), flush (sync kill of both entries)
//   in_valid/in_ready/in_data   : producer side, in_ready registered
//   out_valid/out_ready/out_data: consumer side, driven straight from the main entry
//   occupancy                   : entries held (0..2)
module pipe_skid_buf
  import mem_wb_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occupancy
);

  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] main_data_q, main_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         in_ready_q, in_ready_d;
  logic         accept, drain;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    accept       = in_valid & in_ready_q;
    drain        = main_valid_q & out_ready;

    if (flush) begin
      // A same-cycle drain was already taken downstream; an accept is simply dropped.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // Full: in_ready is low, so only a drain can move things.
      if (drain) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (main_valid_q) begin
      if (accept && drain) begin
        main_data_d = in_data;
      end else if (accept) begin
        skid_data_d  = in_data;
        skid_valid_d = 1'b1;
      end else if (drain) begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      main_data_d  = in_data;
      main_valid_d = 1'b1;
    end

    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign occupancy = occ_count(main_valid_q, skid_valid_q);

endmodule

// File: rtl/mem_wb_skid_n.sv
// MEM/WB pipeline stage for NUM_LANES writeback lanes moved as one atomic issue group.
// Lanes are packed into a two-entry skid buffer; writes to x0 are dropped at capture and
// out_regwrite is gated by out_valid.
// Ports:
//   clk, rst (async, active-low), flush (sync)
//   in_valid/in_ready + in_* lane buses (lane i at slice i of each bus)
//   out_valid/out_ready + out_* lane buses, occupancy (0..2)
// Build option MEM_WB_RESULT_MUX_EN: adds out_result, a per-lane combinational select
// (00 ALU, 01 read_data, 10 pc_plus4, 11 ALU) from the held group.
module mem_wb_skid_n
  import mem_wb_pkg::*;
#(
  parameter int unsigned NUM_LANES = NumLanesDef,
  parameter int unsigned XLEN      = XlenDef,
  parameter int unsigned REG_AW    = RegAwDef
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_LANES-1:0]        in_regwrite,
  input  logic [2*NUM_LANES-1:0]      in_result_src,
  input  logic [XLEN*NUM_LANES-1:0]   in_alu_result,
  input  logic [XLEN*NUM_LANES-1:0]   in_read_data,
  input  logic [REG_AW*NUM_LANES-1:0] in_rd,
  input  logic [XLEN*NUM_LANES-1:0]   in_pc_plus4,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_LANES-1:0]        out_regwrite,
  output logic [2*NUM_LANES-1:0]      out_result_src,
  output logic [XLEN*NUM_LANES-1:0]   out_alu_result,
  output logic [XLEN*NUM_LANES-1:0]   out_read_data,
  output logic [REG_AW*NUM_LANES-1:0] out_rd,
  output logic [XLEN*NUM_LANES-1:0]   out_pc_plus4,
`ifdef MEM_WB_RESULT_MUX_EN
  output logic [XLEN*NUM_LANES-1:0]   out_result,
`endif
  output logic [1:0]                  occupancy
);

  // Same field order as wb_lane_t, at this instance's widths.
  localparam int unsigned LaneW = 1 + 2 + 3 * XLEN + REG_AW;
  localparam int unsigned W     = LaneW * NUM_LANES;

  logic [W-1:0]         in_data;
  logic [W-1:0]         out_data;
  logic [NUM_LANES-1:0] rw_held;
  logic                 out_valid_int;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [REG_AW-1:0] rd_in;
    logic              rw_in;

    assign rd_in = in_rd[i*REG_AW +: REG_AW];
    assign rw_in = in_regwrite[i] & (rd_in != '0);

    assign in_data[i*LaneW +: LaneW] = {rw_in,
                                        in_result_src[2*i +: 2],
                                        in_alu_result[i*XLEN +: XLEN],
                                        in_read_data[i*XLEN +: XLEN],
                                        rd_in,
                                        in_pc_plus4[i*XLEN +: XLEN]};

    assign {rw_held[i],
            out_result_src[2*i +: 2],
            out_alu_result[i*XLEN +: XLEN],
            out_read_data[i*XLEN +: XLEN],
            out_rd[i*REG_AW +: REG_AW],
            out_pc_plus4[i*XLEN +: XLEN]} = out_data[i*LaneW +: LaneW];

`ifdef MEM_WB_RESULT_MUX_EN
    logic [XLEN-1:0] res;

    always_comb begin
      case (result_src_e'(out_result_src[2*i +: 2]))
        RES_MEM: res = out_read_data[i*XLEN +: XLEN];
        RES_PC4: res = out_pc_plus4[i*XLEN +: XLEN];
        default: res = out_alu_result[i*XLEN +: XLEN];  // RES_ALU and reserved
      endcase
    end

    assign out_result[i*XLEN +: XLEN] = res;
`endif
  end

  pipe_skid_buf #(
    .W (W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid_int),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  assign out_valid    = out_valid_int;
  assign out_regwrite = rw_held & {NUM_LANES{out_valid_int}};

endmodule
